// File: rtl/dac_frame_tx.sv
// dac_frame_tx
//   Serial frame transmitter for the DATA and CONVER word loaders. Accepts
//   a pair of N-bit words through a valid/ready handshake. It holds the reset
//   of each selected loader low, then shifts out {word, 1'b1} LSB first. The
//   flag bit therefore lands in the loader's stop position and freezes it.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   data_word    word for the DATA lane
//   conver_word  word for the CONVER lane
//   lane_en      bit0 = DATA, bit1 = CONVER; sampled at accept only
//   valid        send request; accepted when valid && ready
//   ready        high while idle and able to accept
//   ser_data     serial line to the DATA loader
//   ser_conver   serial line to the CONVER loader
//   rx_rst_n     active-low loader resets, bit0 = DATA, bit1 = CONVER
//   done         one-cycle pulse at frame completion
//   busy         ~ready
//
// States
//   state   | meaning
//   S_IDLE  | waiting for valid; loaders released, lines low
//   S_CLR   | RST_CYC cycles holding enabled loaders in reset
//   S_SHIFT | N+1 cycles driving flag then word bits on enabled lanes
//   S_DONE  | one cycle, raises done
//
// All outputs are registered decodes of the current state. Each output
// therefore trails the state by one cycle. The exception is ready, which
// also drops on the accept edge so that a second request cannot be taken
// while the FSM is already leaving IDLE.
module dac_frame_tx #(
  parameter int N       = 8,
  parameter int RST_CYC = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] data_word,
  input  logic [N-1:0] conver_word,
  input  logic [1:0]   lane_en,
  input  logic         valid,
  output logic         ready,
  output logic         ser_data,
  output logic         ser_conver,
  output logic [1:0]   rx_rst_n,
  output logic         done,
  output logic         busy
);

  localparam int SW = $clog2(N + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLR   = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [3:0]    r_clr_cnt, w_clr_cnt_nxt;
  logic [SW-1:0] r_bit_cnt, w_bit_cnt_nxt;
  logic [N-1:0]  r_data_word, r_conver_word;
  logic [1:0]    r_lane_en;

  logic          r_ready, r_busy, r_ser_data, r_ser_conver, r_done;
  logic [1:0]    r_rx_rst_n;
  logic          w_ready_nxt, w_ser_data_nxt, w_ser_conver_nxt, w_done_nxt;
  logic [1:0]    w_rx_rst_n_nxt;

  logic          w_accept;
  logic [N:0]    w_frame_data, w_frame_conver;

  // r_ready high implies the FSM is in IDLE, so accept needs no state term.
  assign w_accept       = valid && r_ready;
  assign w_frame_data   = {r_data_word, 1'b1};
  assign w_frame_conver = {r_conver_word, 1'b1};

  always_comb begin
    w_state_nxt      = r_state;
    w_clr_cnt_nxt    = r_clr_cnt;
    w_bit_cnt_nxt    = r_bit_cnt;
    w_ready_nxt      = 1'b0;
    w_ser_data_nxt   = 1'b0;
    w_ser_conver_nxt = 1'b0;
    w_rx_rst_n_nxt   = 2'b11;
    w_done_nxt       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_ready_nxt = ~w_accept;
        if (w_accept) begin
          if (lane_en == 2'b00) begin
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt   = S_CLR;
            w_clr_cnt_nxt = 4'(RST_CYC - 1);
          end
        end
      end
      S_CLR: begin
        w_rx_rst_n_nxt = ~r_lane_en;
        if (r_clr_cnt == '0) begin
          w_state_nxt   = S_SHIFT;
          w_bit_cnt_nxt = '0;
        end else begin
          w_clr_cnt_nxt = r_clr_cnt - 1'b1;
        end
      end
      S_SHIFT: begin
        w_ser_data_nxt   = r_lane_en[0] & w_frame_data[r_bit_cnt];
        w_ser_conver_nxt = r_lane_en[1] & w_frame_conver[r_bit_cnt];
        if (r_bit_cnt == SW'(N)) begin
          w_state_nxt = S_DONE;
        end else begin
          w_bit_cnt_nxt = r_bit_cnt + 1'b1;
        end
      end
      S_DONE: begin
        w_done_nxt  = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_clr_cnt     <= '0;
      r_bit_cnt     <= '0;
      r_data_word   <= '0;
      r_conver_word <= '0;
      r_lane_en     <= '0;
      r_ready       <= 1'b0;
      r_busy        <= 1'b1;
      r_ser_data    <= 1'b0;
      r_ser_conver  <= 1'b0;
      r_rx_rst_n    <= 2'b00;
      r_done        <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_clr_cnt    <= w_clr_cnt_nxt;
      r_bit_cnt    <= w_bit_cnt_nxt;
      r_ready      <= w_ready_nxt;
      r_busy       <= ~w_ready_nxt;
      r_ser_data   <= w_ser_data_nxt;
      r_ser_conver <= w_ser_conver_nxt;
      r_rx_rst_n   <= w_rx_rst_n_nxt;
      r_done       <= w_done_nxt;
      if (w_accept) begin
        r_data_word   <= data_word;
        r_conver_word <= conver_word;
        r_lane_en     <= lane_en;
      end
    end
  end

  assign ready      = r_ready;
  assign busy       = r_busy;
  assign ser_data   = r_ser_data;
  assign ser_conver = r_ser_conver;
  assign rx_rst_n   = r_rx_rst_n;
  assign done       = r_done;

endmodule

// File: tb/tb_dac_frame_tx.sv
// Testbench for dac_frame_tx. It models the two serial word loaders and
// checks the per-cycle output traces of each frame against traces computed
// from the frame rules. It also checks the final loader contents against a
// word-level model.
module tb_dac_frame_tx;

  localparam int N       = 8;
  localparam int RST_CYC = 2;
  localparam int FL      = RST_CYC + N + 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] data_word = '0, conver_word = '0;
  logic [1:0] lane_en = '0;
  logic       valid = 1'b0;
  logic       ready, ser_data, ser_conver, done, busy;
  logic [1:0] rx_rst_n;

  dac_frame_tx #(.N(N), .RST_CYC(RST_CYC)) dut (
    .clk(clk), .rst(rst), .data_word(data_word), .conver_word(conver_word),
    .lane_en(lane_en), .valid(valid), .ready(ready), .ser_data(ser_data),
    .ser_conver(ser_conver), .rx_rst_n(rx_rst_n), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Loader models: bit0 is the stop flag, input enters at bit8.
  logic [8:0] ld0 = '0, ld1 = '0;
  logic       pre_req = 1'b0;
  logic [7:0] pre_v0 = '0, pre_v1 = '0;

  always @(posedge clk or negedge rx_rst_n[0])
    if (!rx_rst_n[0])   ld0 <= '0;
    else if (pre_req)   ld0 <= {pre_v0, 1'b1};
    else if (!ld0[0])   ld0 <= {ser_data, ld0[8:1]};

  always @(posedge clk or negedge rx_rst_n[1])
    if (!rx_rst_n[1])   ld1 <= '0;
    else if (pre_req)   ld1 <= {pre_v1, 1'b1};
    else if (!ld1[0])   ld1 <= {ser_conver, ld1[8:1]};

  // Word-level expectation of each loader's content.
  logic [8:0] m0 = '0, m1 = '0;

  task automatic preload(input logic [7:0] v0, input logic [7:0] v1);
    @(negedge clk);
    pre_v0 = v0; pre_v1 = v1; pre_req = 1'b1;
    @(negedge clk);
    pre_req = 1'b0;
    m0 = {v0, 1'b1};
    m1 = {v1, 1'b1};
  endtask

  // Expected traces, indexed by negedges after the accept edge (c=0).
  function automatic void model_trace(input logic [7:0] dw, input logic [7:0] cw,
                                      input logic [1:0] en,
                                      output logic [15:0] e_sd, output logic [15:0] e_sc,
                                      output logic [15:0] e_r0, output logic [15:0] e_r1,
                                      output logic [15:0] e_dn, output logic [15:0] e_rdy,
                                      output logic [15:0] e_bz);
    logic [8:0] f0, f1;
    int lat, k;
    f0  = {dw, 1'b1};
    f1  = {cw, 1'b1};
    lat = (en == 2'b00) ? 1 : FL;
    e_sd = '0; e_sc = '0; e_r0 = '0; e_r1 = '0; e_dn = '0; e_rdy = '0; e_bz = '0;
    for (int c = 0; c < 16; c++) begin
      k = c - (RST_CYC + 1);
      if (k >= 0 && k <= N) begin
        e_sd[c] = en[0] & f0[k];
        e_sc[c] = en[1] & f1[k];
      end
      e_r0[c]  = !(en[0] && c >= 1 && c <= RST_CYC);
      e_r1[c]  = !(en[1] && c >= 1 && c <= RST_CYC);
      e_dn[c]  = (c == lat);
      e_rdy[c] = (c > lat);
      e_bz[c]  = !(c > lat);
    end
  endfunction

  function automatic int first_one(input logic [15:0] v);
    for (int c = 0; c < 16; c++) if (v[c]) return c;
    return 99;
  endfunction

  task automatic wait_ready(input string tag);
    int t = 0;
    while (!ready && t < 40) begin @(negedge clk); t++; end
    chk({tag, "_accept_wait"}, 32'(t < 40), 32'd1);
  endtask

  // Request one frame and record 16 cycles of outputs from the accept edge.
  // junk_c >= 0 pulses valid with other data at that cycle while busy.
  task automatic send(input logic [7:0] dw, input logic [7:0] cw, input logic [1:0] en,
                      input int junk_c,
                      output logic [15:0] t_sd, output logic [15:0] t_sc,
                      output logic [15:0] t_r0, output logic [15:0] t_r1,
                      output logic [15:0] t_dn, output logic [15:0] t_rdy,
                      output logic [15:0] t_bz);
    @(negedge clk);
    data_word = dw; conver_word = cw; lane_en = en; valid = 1'b1;
    wait_ready("send");
    @(negedge clk);
    valid       = 1'b0;
    data_word   = 8'($urandom);
    conver_word = 8'($urandom);
    lane_en     = 2'($urandom);
    for (int c = 0; c < 16; c++) begin
      t_sd[c] = ser_data;    t_sc[c] = ser_conver;
      t_r0[c] = rx_rst_n[0]; t_r1[c] = rx_rst_n[1];
      t_dn[c] = done;        t_rdy[c] = ready;  t_bz[c] = busy;
      valid = (c == junk_c);
      if (c == junk_c) begin
        data_word = 8'h12; conver_word = 8'h12; lane_en = 2'b11;
      end
      if (c < 15) @(negedge clk);
    end
    valid = 1'b0;
  endtask

  task automatic run_check(input string tag, input logic [7:0] dw, input logic [7:0] cw,
                           input logic [1:0] en, input int junk_c);
    logic [15:0] t_sd, t_sc, t_r0, t_r1, t_dn, t_rdy, t_bz;
    logic [15:0] e_sd, e_sc, e_r0, e_r1, e_dn, e_rdy, e_bz;
    model_trace(dw, cw, en, e_sd, e_sc, e_r0, e_r1, e_dn, e_rdy, e_bz);
    send(dw, cw, en, junk_c, t_sd, t_sc, t_r0, t_r1, t_dn, t_rdy, t_bz);
    if (en[0]) m0 = {dw, 1'b1};
    if (en[1]) m1 = {cw, 1'b1};
    chk({tag, "_ser_data"},   32'(t_sd),  32'(e_sd));
    chk({tag, "_ser_conver"}, 32'(t_sc),  32'(e_sc));
    chk({tag, "_rx_rst_n0"},  32'(t_r0),  32'(e_r0));
    chk({tag, "_rx_rst_n1"},  32'(t_r1),  32'(e_r1));
    chk({tag, "_done"},       32'(t_dn),  32'(e_dn));
    chk({tag, "_ready"},      32'(t_rdy), 32'(e_rdy));
    chk({tag, "_busy"},       32'(t_bz),  32'(e_bz));
    chk({tag, "_loader_data"},   32'(ld0), 32'(m0));
    chk({tag, "_loader_conver"}, 32'(ld1), 32'(m1));
  endtask

  typedef struct {
    logic [7:0] dw, cw;
    logic [1:0] en;
    logic [7:0] p0, p1;
    int         lat;
    logic [7:0] w0, w1;
    int         rl0, rl1;
  } vec_t;

  initial begin
    vec_t        tbl[5];
    logic [15:0] t_sd, t_sc, t_r0, t_r1, t_dn, t_rdy, t_bz;
    logic [8:0]  fa;
    int          c, seen;
    logic [7:0]  rdw, rcw;
    logic [1:0]  ren;

    tbl[0] = '{8'hA5, 8'h3C, 2'b11, 8'h00, 8'h00, 12, 8'hA5, 8'h3C, 2, 2};
    tbl[1] = '{8'hFF, 8'h99, 2'b01, 8'h00, 8'h55, 12, 8'hFF, 8'h55, 2, 0};
    tbl[2] = '{8'h00, 8'h81, 2'b10, 8'h77, 8'h00, 12, 8'h77, 8'h81, 0, 2};
    tbl[3] = '{8'h12, 8'h34, 2'b00, 8'h5A, 8'hC3,  1, 8'h5A, 8'hC3, 0, 0};
    tbl[4] = '{8'h0F, 8'hF0, 2'b11, 8'h33, 8'hCC, 12, 8'h0F, 8'hF0, 2, 2};

    // Power-on reset and release.
    #1 rst = 1'b1;
    #1;
    chk("rst_rx_rst_n", 32'(rx_rst_n), 32'h0);
    chk("rst_ready",    32'(ready), 32'h0);
    chk("rst_busy",     32'(busy), 32'h1);
    chk("rst_ser",      32'({ser_data, ser_conver}), 32'h0);
    chk("rst_done",     32'(done), 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1 chk("rel_before_edge_rx", 32'(rx_rst_n), 32'h0);
    @(negedge clk);
    chk("rel_rx_rst_n", 32'(rx_rst_n), 32'h3);
    chk("rel_ready",    32'(ready), 32'h1);
    chk("rel_busy",     32'(busy), 32'h0);

    // Reset asserted mid-cycle takes effect without a clock edge.
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_rx_rst_n", 32'(rx_rst_n), 32'h0);
    chk("mid_rst_ready",    32'(ready), 32'h0);
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    chk("mid_rel_rx_rst_n", 32'(rx_rst_n), 32'h3);
    chk("mid_rel_ready",    32'(ready), 32'h1);

    // Table-driven frames with preloaded loaders.
    for (int i = 0; i < 5; i++) begin
      preload(tbl[i].p0, tbl[i].p1);
      send(tbl[i].dw, tbl[i].cw, tbl[i].en, -1, t_sd, t_sc, t_r0, t_r1, t_dn, t_rdy, t_bz);
      chk($sformatf("tbl%0d_latency", i), 32'(first_one(t_dn)), 32'(tbl[i].lat));
      chk($sformatf("tbl%0d_rlow0", i), 32'(16 - $countones(t_r0)), 32'(tbl[i].rl0));
      chk($sformatf("tbl%0d_rlow1", i), 32'(16 - $countones(t_r1)), 32'(tbl[i].rl1));
      chk($sformatf("tbl%0d_loader_data", i),   32'(ld0), 32'({tbl[i].w0, 1'b1}));
      chk($sformatf("tbl%0d_loader_conver", i), 32'(ld1), 32'({tbl[i].w1, 1'b1}));
      if (tbl[i].en[0])
        chk($sformatf("tbl%0d_data_seq", i), 32'(t_sd[RST_CYC+1 +: 9]), 32'({tbl[i].dw, 1'b1}));
      else
        chk($sformatf("tbl%0d_data_idle", i), 32'(t_sd), 32'h0);
      if (tbl[i].en[1])
        chk($sformatf("tbl%0d_conver_seq", i), 32'(t_sc[RST_CYC+1 +: 9]), 32'({tbl[i].cw, 1'b1}));
      else
        chk($sformatf("tbl%0d_conver_idle", i), 32'(t_sc), 32'h0);
      m0 = {tbl[i].w0, 1'b1};
      m1 = {tbl[i].w1, 1'b1};
    end

    // valid pulsed with 8'h12 while the frame is shifting.
    run_check("busy_rej", 8'h3C, 8'hC3, 2'b11, RST_CYC + 3);

    // valid held: 8'h01 then 8'h80, second accepted right after done.
    @(negedge clk);
    data_word = 8'h01; conver_word = 8'h01; lane_en = 2'b11; valid = 1'b1;
    wait_ready("b2b1");
    @(negedge clk);
    data_word = 8'h80; conver_word = 8'h80;
    c = 0;
    while (!done && c < 30) begin @(negedge clk); c++; end
    chk("b2b_lat1", 32'(c), 32'(FL));
    chk("b2b_loader_data1",   32'(ld0), 32'({8'h01, 1'b1}));
    chk("b2b_loader_conver1", 32'(ld1), 32'({8'h01, 1'b1}));
    @(negedge clk);
    chk("b2b_ready_after_done", 32'(ready), 32'h1);
    @(negedge clk);
    chk("b2b_reaccepted", 32'(ready), 32'h0);
    valid = 1'b0;
    c = 0;
    while (!done && c < 30) begin @(negedge clk); c++; end
    chk("b2b_lat2", 32'(c), 32'(FL));
    chk("b2b_loader_data2",   32'(ld0), 32'({8'h80, 1'b1}));
    chk("b2b_loader_conver2", 32'(ld1), 32'({8'h80, 1'b1}));
    m0 = {8'h80, 1'b1};
    m1 = {8'h80, 1'b1};
    repeat (2) @(negedge clk);

    // Abort with rst while bit k=4 is on the lines.
    fa = {8'hC3, 1'b1};
    @(negedge clk);
    data_word = 8'hC3; conver_word = 8'hC3; lane_en = 2'b11; valid = 1'b1;
    wait_ready("abort");
    @(negedge clk);
    valid = 1'b0;
    repeat (RST_CYC + 1 + 4) @(negedge clk);
    chk("abort_k4_bit", 32'(ser_data), 32'(fa[4]));
    rst = 1'b1;
    #1;
    chk("abort_rx_rst_n",     32'(rx_rst_n), 32'h0);
    chk("abort_loader_data",  32'(ld0), 32'h0);
    chk("abort_loader_conv",  32'(ld1), 32'h0);
    chk("abort_ready",        32'(ready), 32'h0);
    @(negedge clk) rst = 1'b0;
    seen = 0;
    repeat (16) begin @(negedge clk); if (done) seen++; end
    chk("abort_no_done", 32'(seen), 32'h0);
    chk("abort_loader_idle", 32'({ld0, ld1}), 32'h0);
    m0 = '0;
    m1 = '0;
    run_check("after_abort", 8'h0F, 8'h0F, 2'b11, -1);

    // Randomized frames against the model.
    for (int i = 0; i < 20; i++) begin
      rdw = 8'($urandom);
      rcw = 8'($urandom);
      ren = 2'($urandom);
      if ($urandom_range(0, 3) == 0) preload(8'($urandom), 8'($urandom));
      run_check($sformatf("rnd%0d", i), rdw, rcw, ren,
                (ren != 2'b00 && $urandom_range(0, 1) == 1) ? int'($urandom_range(1, 9)) : -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
